decade_step_ctrl: RTL

//  Synchronous sequencer for the JK ripple decade counter (BCD 0-9, advances on falling edge of its

---
 rtl/decade_step_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/decade_step_ctrl.sv
// Sequencer for a JK ripple BCD decade counter. It pulses the counter's count
// input until the counter reads the requested target. A shadow copy of the
// expected count is kept, and every step is checked once the ripple has settled.
module decade_step_ctrl #(
  parameter int PULSE_WIDTH   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] target,
  input  logic [3:0] q,
  output logic       cnt_x,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] steps,
  output logic       wrapped
);

  // The timer is wide enough for the longer of the two waits.
  localparam int TMAX = (PULSE_WIDTH > SETTLE_CYCLES) ? PULSE_WIDTH : SETTLE_CYCLES;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_CHECK, S_HIGH, S_SETTLE, S_VERIFY, S_DONE, S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    q_s1_q, q_s_q;
  logic [3:0]    target_q, target_d;
  logic [3:0]    expected_q, expected_d;
  logic [3:0]    steps_q, steps_d;
  logic          wrapped_q, wrapped_d;
  logic          err_q, err_d;
  logic          cnt_x_q, cnt_x_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort_pend_q, abort_pend_d;
  logic          target_ok;

  assign target_ok = (target <= 4'd9);

  // Two-flop synchronizer for the counter's asynchronous outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s1_q <= '0;
      q_s_q  <= '0;
    end else begin
      q_s1_q <= q;
      q_s_q  <= q_s1_q;
    end
  end

  // Next-state and output computation. Outputs are derived from the next state
  // so that every output is registered.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    target_d     = target_q;
    expected_d   = expected_q;
    steps_d      = steps_q;
    wrapped_d    = wrapped_q;
    err_d        = err_q;
    abort_pend_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          if (target_ok) begin
            state_d   = S_SAMPLE;
            target_d  = target;
            steps_d   = '0;
            wrapped_d = 1'b0;
            err_d     = 1'b0;
            timer_d   = TW'(SETTLE_CYCLES);
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end

      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          if (q_s_q > 4'd9) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            expected_d = q_s_q;
            state_d    = S_CHECK;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (expected_q == target_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_HIGH;
          timer_d = TW'(PULSE_WIDTH - 1);
        end
      end

      // An abort is remembered and acted on only once the pulse has run its
      // full width. This keeps the counter from seeing a runt pulse.
      S_HIGH: begin
        abort_pend_d = abort_pend_q | abort;
        if (timer_q == '0) begin
          expected_d   = (expected_q == 4'd9) ? 4'd0 : expected_q + 4'd1;
          steps_d      = steps_q + 4'd1;
          wrapped_d    = wrapped_q | (expected_q == 4'd9);
          abort_pend_d = 1'b0;
          if (abort_pend_q | abort) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SETTLE;
            timer_d = TW'(SETTLE_CYCLES - 1);
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_VERIFY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_VERIFY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (q_s_q != expected_q) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else if (q_s_q == target_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_HIGH;
          timer_d = TW'(PULSE_WIDTH - 1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cnt_x_d = (state_d == S_HIGH);
    busy_d  = (state_d != S_IDLE) && (state_d != S_ERROR);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      target_q     <= '0;
      expected_q   <= '0;
      steps_q      <= '0;
      wrapped_q    <= 1'b0;
      err_q        <= 1'b0;
      cnt_x_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      target_q     <= target_d;
      expected_q   <= expected_d;
      steps_q      <= steps_d;
      wrapped_q    <= wrapped_d;
      err_q        <= err_d;
      cnt_x_q      <= cnt_x_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign cnt_x   = cnt_x_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign steps   = steps_q;
  assign wrapped = wrapped_q;

endmodule
